// File: rtl/sd_spi_responder_if.sv
// SPI bus between an SD host controller (master) and the card (slave).
interface sd_spi_responder_if;
    logic sdCS;
    logic sdSCLK;
    logic sdMOSI;
    logic sdMISO;

    modport master (output sdCS, sdSCLK, sdMOSI, input sdMISO);
    modport slave  (input sdCS, sdSCLK, sdMOSI, output sdMISO);
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card emulator: decodes the boot command subset and serves
// 512-byte blocks from a byte-wide memory port.
module sd_spi_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int BUSY_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  n_reset,
    sd_spi_responder_if.slave     spi,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    output logic                  idle
);
    localparam int LBA_W = ADDR_WIDTH - 9;

    typedef enum logic [3:0] {
        WAIT_CMD, CMD_RX, RESP, RD_TOKEN, RD_DATA, RD_CRC,
        WR_TOKEN, WR_DATA, WR_CRC, WR_DRESP
    } state_t;
    typedef enum logic [1:0] {NX_IDLE, NX_READ, NX_WRITE} next_t;

    logic [1:0]            cs_s_q, sclk_s_q, mosi_s_q;
    logic                  cs_prev_q, sclk_prev_q;
    logic [2:0]            bitcnt_q;
    logic [7:0]            rx_q, tx_q, rdbuf_q, wbuf_q, wdata_q;
    logic                  miso_q;
    state_t                state_q;
    next_t                 nx_q;
    logic [5:0]            cmd_q;
    logic [31:0]           arg_q;
    logic [7:0]            cnt_q;
    logic [2:0]            rlen_q;
    logic [4:0][7:0]       rbuf_q;
    logic [8:0]            idx_q, widx_q;
    logic [LBA_W-1:0]      lba_q;
    logic                  app_q, idle_q, rd_q, rdpend_q, we_q, wpend_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic       cs_hi, cs_fall, sclk_rise, sclk_fall, byte_done;
    logic [7:0] rx_d, r1_d;

    assign cs_hi     = cs_s_q[1];
    assign cs_fall   = cs_prev_q & ~cs_s_q[1];
    assign sclk_rise = ~sclk_prev_q & sclk_s_q[1];
    assign sclk_fall = sclk_prev_q & ~sclk_s_q[1];
    // CS high suppresses a byte that completes on the same clk
    assign byte_done = ~cs_hi & sclk_rise & (bitcnt_q == 3'd7);
    assign rx_d      = {rx_q[6:0], mosi_s_q[1]};
    assign r1_d      = {7'd0, idle_q};

    assign spi.sdMISO = miso_q;
    assign mem_addr   = addr_q;
    assign mem_rd     = rd_q;
    assign mem_we     = we_q;
    assign mem_wdata  = wdata_q;
    assign idle       = idle_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cs_s_q      <= 2'b11;
            sclk_s_q    <= 2'b00;
            mosi_s_q    <= 2'b11;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_s_q      <= {cs_s_q[0], spi.sdCS};
            sclk_s_q    <= {sclk_s_q[0], spi.sdSCLK};
            mosi_s_q    <= {mosi_s_q[0], spi.sdMOSI};
            cs_prev_q   <= cs_s_q[1];
            sclk_prev_q <= sclk_s_q[1];
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bitcnt_q <= '0;  rx_q    <= '0;      tx_q   <= 8'hFF;  miso_q  <= 1'b1;
            state_q  <= WAIT_CMD;                nx_q   <= NX_IDLE;
            cmd_q    <= '0;  arg_q   <= '0;      cnt_q  <= '0;     rlen_q  <= 3'd1;
            rbuf_q   <= '0;  idx_q   <= '0;      widx_q <= '0;     lba_q   <= '0;
            app_q    <= 1'b0; idle_q <= 1'b1;    rd_q   <= 1'b0;   rdpend_q <= 1'b0;
            we_q     <= 1'b0; wpend_q <= 1'b0;   addr_q <= '0;     wdata_q <= '0;
            rdbuf_q  <= '0;  wbuf_q  <= '0;
        end else begin
            rd_q     <= 1'b0;
            we_q     <= 1'b0;
            rdpend_q <= rd_q;
            if (rdpend_q) rdbuf_q <= mem_rdata;
            // the write strobe trails the completed byte by one register stage
            if (wpend_q && !cs_hi) begin
                we_q    <= 1'b1;
                addr_q  <= {lba_q, widx_q};
                wdata_q <= wbuf_q;
                wpend_q <= 1'b0;
            end

            if (cs_hi) begin
                bitcnt_q <= '0;
                miso_q   <= 1'b1;
                tx_q     <= 8'hFF;
                state_q  <= WAIT_CMD;
                cnt_q    <= '0;
                wpend_q  <= 1'b0;
            end else begin
                if (cs_fall)
                    miso_q <= tx_q[7];
                else if (sclk_fall)
                    miso_q <= tx_q[3'd7 - bitcnt_q];
                if (sclk_rise) begin
                    rx_q     <= rx_d;
                    bitcnt_q <= bitcnt_q + 3'd1;
                end
            end

            if (byte_done) begin
                tx_q <= 8'hFF;
                unique case (state_q)
                    WAIT_CMD: if (rx_d[7:6] == 2'b01) begin
                        cmd_q   <= rx_d[5:0];
                        cnt_q   <= '0;
                        state_q <= CMD_RX;
                    end
                    CMD_RX: if (cnt_q != 8'd4) begin
                        arg_q <= {arg_q[23:0], rx_d};
                        cnt_q <= cnt_q + 8'd1;
                    end else begin
                        // CRC byte done: build the response, NCR slot is 0xFF
                        state_q <= RESP;
                        cnt_q   <= '0;
                        nx_q    <= NX_IDLE;
                        rlen_q  <= 3'd1;
                        app_q   <= 1'b0;
                        rbuf_q  <= '0;
                        unique case (cmd_q)
                            6'd0:  begin idle_q <= 1'b1; rbuf_q[0] <= 8'h01; end
                            6'd8:  begin
                                rbuf_q[0] <= r1_d;
                                rbuf_q[3] <= arg_q[15:8];
                                rbuf_q[4] <= arg_q[7:0];
                                rlen_q    <= 3'd5;
                            end
                            6'd55: begin app_q <= 1'b1; rbuf_q[0] <= r1_d; end
                            6'd41: if (app_q) idle_q <= 1'b0;
                                   else rbuf_q[0] <= r1_d | 8'h04;
                            6'd58: begin
                                rbuf_q <= {8'h00, 8'h80, 8'hFF, 8'hC0, r1_d};
                                rlen_q <= 3'd5;
                            end
                            6'd16: rbuf_q[0] <= r1_d;
                            6'd17, 6'd24: begin
                                if (idle_q)
                                    rbuf_q[0] <= 8'h05;
                                else if (arg_q[31:LBA_W] != '0)
                                    rbuf_q[0] <= 8'h40;
                                else begin
                                    lba_q <= arg_q[LBA_W-1:0];
                                    nx_q  <= (cmd_q == 6'd17) ? NX_READ : NX_WRITE;
                                end
                            end
                            default: rbuf_q[0] <= r1_d | 8'h04;
                        endcase
                    end
                    RESP: if (cnt_q[2:0] < rlen_q) begin
                        tx_q  <= rbuf_q[cnt_q[2:0]];
                        cnt_q <= cnt_q + 8'd1;
                    end else begin
                        cnt_q <= '0;
                        unique case (nx_q)
                            NX_READ:  state_q <= RD_TOKEN;
                            NX_WRITE: state_q <= WR_TOKEN;
                            default:  state_q <= WAIT_CMD;
                        endcase
                    end
                    RD_TOKEN: begin
                        tx_q    <= 8'hFE;
                        idx_q   <= '0;
                        rd_q    <= 1'b1;
                        addr_q  <= {lba_q, 9'd0};
                        state_q <= RD_DATA;
                    end
                    // each slot loads the buffered byte and prefetches the next
                    RD_DATA: begin
                        tx_q <= rdbuf_q;
                        if (idx_q == 9'd511) begin
                            cnt_q   <= '0;
                            state_q <= RD_CRC;
                        end else begin
                            idx_q  <= idx_q + 9'd1;
                            rd_q   <= 1'b1;
                            addr_q <= {lba_q, idx_q + 9'd1};
                        end
                    end
                    RD_CRC: if (cnt_q == 8'd2) state_q <= WAIT_CMD;
                            else cnt_q <= cnt_q + 8'd1;
                    WR_TOKEN: if (rx_d == 8'hFE) begin
                        idx_q   <= '0;
                        state_q <= WR_DATA;
                    end
                    WR_DATA: begin
                        wbuf_q  <= rx_d;
                        widx_q  <= idx_q;
                        wpend_q <= 1'b1;
                        if (idx_q == 9'd511) begin
                            cnt_q   <= '0;
                            state_q <= WR_CRC;
                        end else
                            idx_q <= idx_q + 9'd1;
                    end
                    WR_CRC: if (cnt_q == 8'd1) begin
                        tx_q    <= 8'h05;
                        cnt_q   <= '0;
                        state_q <= WR_DRESP;
                    end else
                        cnt_q <= cnt_q + 8'd1;
                    WR_DRESP: if (cnt_q < 8'(BUSY_BYTES)) begin
                        tx_q  <= 8'h00;
                        cnt_q <= cnt_q + 8'd1;
                    end else
                        state_q <= WAIT_CMD;
                    default: state_q <= WAIT_CMD;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_spi_responder.sv
// Drives the responder as an SPI host; MISO bytes are checked through a queue.
module tb_sd_spi_responder;
    localparam int HALF = 3;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_we, idle;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem_wdata;

    sd_spi_responder_if spi();

    sd_spi_responder #(.ADDR_WIDTH(16), .BUSY_BYTES(4)) dut (
        .clk(clk), .n_reset(n_reset), .spi(spi.slave),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int we_cnt = 0;
    logic [15:0] rd_lo = 16'hFFFF;
    logic [15:0] rd_hi = 16'h0000;
    logic [7:0] wmem [0:65535];
    logic [7:0] exp_q [$];

    // Backing store: block 3 reads as idx^0x5A, everything else from written data
    always @(posedge clk) begin
        if (mem_rd) begin
            rd_cnt++;
            if (mem_addr < rd_lo) rd_lo = mem_addr;
            if (mem_addr > rd_hi) rd_hi = mem_addr;
            mem_rdata <= (mem_addr[15:9] == 7'd3) ? (mem_addr[7:0] ^ 8'h5A) : wmem[mem_addr];
        end
        if (mem_we) begin
            we_cnt++;
            wmem[mem_addr] <= mem_wdata;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: run did not finish, checks=%0d", n_chk);
        $fatal(1, "timeout");
    end

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int b = 7; b >= 0; b--) begin
            spi.sdMOSI = tx[b];
            repeat (HALF) @(negedge clk);
            rx[b] = spi.sdMISO;
            spi.sdSCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            spi.sdSCLK = 1'b0;
        end
    endtask

    task automatic sb_byte(input logic [7:0] tx, input logic [7:0] exp, input string nm);
        logic [7:0] rx, e;
        exp_q.push_back(exp);
        xfer(tx, rx);
        e = exp_q.pop_front();
        n_chk++;
        if (rx !== e) begin
            n_fail++;
            $display("FAIL %s: miso byte got %02h want %02h", nm, rx, e);
        end
    endtask

    task automatic cs_low();
        spi.sdCS = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        spi.sdCS = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [5:0] c, input logic [31:0] arg, input string nm);
        sb_byte({2'b01, c}, 8'hFF, nm);
        for (int i = 3; i >= 0; i--) sb_byte(arg[i*8 +: 8], 8'hFF, nm);
        sb_byte(8'h95, 8'hFF, nm);
        sb_byte(8'hFF, 8'hFF, {nm, "_ncr"});
    endtask

    task automatic cmd_r1(input logic [5:0] c, input logic [31:0] arg, input logic [7:0] r1, input string nm);
        cs_low();
        send_cmd(c, arg, nm);
        sb_byte(8'hFF, r1, {nm, "_r1"});
        cs_high();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({spi.sdMISO, mem_rd, mem_we, idle} !== 4'b1001) begin
            n_fail++;
            $display("FAIL reset_ctl: miso/rd/we/idle got %b want 1001", {spi.sdMISO, mem_rd, mem_we, idle});
        end
        n_chk++;
        if ({mem_addr, mem_wdata} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_bus: addr/wdata got %06h want 000000", {mem_addr, mem_wdata});
        end
        n_reset = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++;
        if (spi.sdMISO !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_miso: got %b want 1", spi.sdMISO);
        end
    endtask

    task automatic test_cmd_basic();
        logic [31:0] a;
        cmd_r1(6'd0, 32'h0, 8'h01, "cmd0");
        n_chk++;
        if (idle !== 1'b1) begin n_fail++; $display("FAIL cmd0_idle: got %b want 1", idle); end
        a = 32'h000001AA;
        cs_low();
        send_cmd(6'd8, a, "cmd8");
        sb_byte(8'hFF, 8'h01, "cmd8_r7_0");
        sb_byte(8'hFF, 8'h00, "cmd8_r7_1");
        sb_byte(8'hFF, 8'h00, "cmd8_r7_2");
        sb_byte(8'hFF, a[15:8], "cmd8_r7_3");
        sb_byte(8'hFF, a[7:0], "cmd8_r7_4");
        cs_high();
        cmd_r1(6'd17, 32'd3, 8'h05, "cmd17_idle");
        cmd_r1(6'd41, 32'h0, 8'h05, "cmd41_noapp");
    endtask

    task automatic test_init();
        logic [7:0] ocr [5];
        ocr = '{8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00};
        cmd_r1(6'd55, 32'h0, 8'h01, "cmd55");
        cmd_r1(6'd41, 32'h40000000, 8'h00, "acmd41");
        n_chk++;
        if (idle !== 1'b0) begin n_fail++; $display("FAIL acmd41_idle: got %b want 0", idle); end
        cs_low();
        send_cmd(6'd58, 32'h0, "cmd58");
        for (int i = 0; i < 5; i++) sb_byte(8'hFF, ocr[i], "cmd58_r3");
        cs_high();
        cmd_r1(6'd16, 32'd512, 8'h00, "cmd16");
        cmd_r1(6'd1, 32'h0, 8'h04, "cmd1_illegal");
        cmd_r1(6'd17, 32'd128, 8'h40, "cmd17_oob");
        cmd_r1(6'd24, 32'h00010000, 8'h40, "cmd24_oob");
    endtask

    task automatic test_read();
        int rd0;
        rd0 = rd_cnt;
        cs_low();
        send_cmd(6'd17, 32'd3, "cmd17");
        sb_byte(8'hFF, 8'h00, "cmd17_r1");
        sb_byte(8'hFF, 8'hFF, "rd_gap");
        sb_byte(8'hFF, 8'hFE, "rd_token");
        for (int i = 0; i < 512; i++) begin
            logic [8:0] ii;
            ii = 9'(i);
            sb_byte(8'hFF, ii[7:0] ^ 8'h5A, "rd_data");
        end
        sb_byte(8'hFF, 8'hFF, "rd_crc0");
        sb_byte(8'hFF, 8'hFF, "rd_crc1");
        cs_high();
        n_chk++;
        if (rd_cnt - rd0 != 512) begin
            n_fail++;
            $display("FAIL rd_strobes: got %0d want 512", rd_cnt - rd0);
        end
        n_chk++;
        if (rd_lo !== 16'h0600 || rd_hi !== 16'h07FF) begin
            n_fail++;
            $display("FAIL rd_span: got %04h-%04h want 0600-07FF", rd_lo, rd_hi);
        end
    endtask

    task automatic test_write();
        int we0, bad;
        we0 = we_cnt;
        cs_low();
        send_cmd(6'd24, 32'd5, "cmd24");
        sb_byte(8'hFF, 8'h00, "cmd24_r1");
        sb_byte(8'hFF, 8'hFF, "wr_gap");
        sb_byte(8'hFE, 8'hFF, "wr_token");
        for (int i = 0; i < 512; i++) sb_byte(8'(i), 8'hFF, "wr_data");
        sb_byte(8'h12, 8'hFF, "wr_crc0");
        sb_byte(8'h34, 8'hFF, "wr_crc1");
        sb_byte(8'hFF, 8'h05, "wr_dresp");
        for (int i = 0; i < 4; i++) sb_byte(8'hFF, 8'h00, "wr_busy");
        sb_byte(8'hFF, 8'hFF, "wr_ready");
        cs_high();
        n_chk++;
        if (we_cnt - we0 != 512) begin
            n_fail++;
            $display("FAIL wr_strobes: got %0d want 512", we_cnt - we0);
        end
        bad = 0;
        for (int i = 0; i < 512; i++)
            if (wmem[16'h0A00 + 16'(i)] !== 8'(i)) bad++;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wr_mem: %0d bytes differ, want 0", bad);
        end
    endtask

    task automatic test_abort();
        int we0;
        we0 = we_cnt;
        cs_low();
        send_cmd(6'd24, 32'd6, "cmd24_ab");
        sb_byte(8'hFF, 8'h00, "cmd24_ab_r1");
        sb_byte(8'hFE, 8'hFF, "ab_token");
        for (int i = 0; i < 100; i++) sb_byte(8'(i + 7), 8'hFF, "ab_data");
        cs_high();
        repeat (40) @(negedge clk);
        n_chk++;
        if (we_cnt - we0 != 100) begin
            n_fail++;
            $display("FAIL ab_strobes: got %0d want 100", we_cnt - we0);
        end
        n_chk++;
        if (spi.sdMISO !== 1'b1) begin
            n_fail++;
            $display("FAIL ab_miso: got %b want 1", spi.sdMISO);
        end
        n_chk++;
        if (wmem[16'h0C63] !== 8'd106) begin
            n_fail++;
            $display("FAIL ab_last: got %02h want 6a", wmem[16'h0C63]);
        end
        cmd_r1(6'd0, 32'h0, 8'h01, "cmd0_after_abort");
    endtask

    initial begin
        spi.sdCS = 1'b1;
        spi.sdSCLK = 1'b0;
        spi.sdMOSI = 1'b1;
        test_reset();
        test_cmd_basic();
        test_init();
        test_read();
        test_write();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_spi_responder.md
# sd_spi_responder

SPI-mode SD card responder: the card side of the interface that `sd_controller` drives over `sdCS`/`sdMOSI`/`sdSCLK`/`sdMISO`. It decodes the SD command subset the controller uses (CMD0/8/55/ACMD41/58/16/17/24) and returns R1/R3/R7 responses. Read and write blocks are served from a byte-wide memory port. It replaces the physical card in simulation benches and lets FPGA builds boot CP/M from on-chip RAM.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: byte address width of the backing memory. Capacity is 2^(ADDR_WIDTH-9) blocks of 512 bytes.
- `BUSY_BYTES`, 4: number of 0x00 busy bytes sent after a write data response.

Ports:
- `clk` in 1: system clock. Must be ≥ 4× the SCLK frequency.
- `n_reset` in 1: asynchronous, active-low reset.
- `sdCS` in 1: chip select, active low.
- `sdSCLK` in 1: SPI clock, mode 0.
- `sdMOSI` in 1: command and data from the controller.
- `sdMISO` out 1: response and data to the controller.
- `mem_addr` out ADDR_WIDTH: byte address into the backing memory.
- `mem_rd` out 1: one-clk read strobe. `mem_rdata` is valid on the next clk.
- `mem_rdata` in 8: read data.
- `mem_we` out 1: one-clk write strobe.
- `mem_wdata` out 8: write data.
- `idle` out 1: card is in the idle state (R1 bit 0).

## Operation
**Input synchronisation**
- `sdCS`, `sdSCLK` and `sdMOSI` each pass through a 2-flop synchroniser before use.
- SCLK rising edge: MOSI is shifted in MSB first and the bit counter increments.
- SCLK falling edge: the next MISO bit is driven.
- A byte completes on the 8th rising edge.

**Chip select**
- CS high: bit counter cleared, MISO = 1, FSM returns to `WAIT_CMD`. This applies mid-transfer as well; a block transfer in progress is aborted and no further `mem_we` is issued.
- CS falling: bit 7 of the current tx byte is driven immediately.

**Transmit byte loading**
- The tx byte for slot n+1 is loaded at completion of slot n.
- In every state without pending output, the tx byte is 0xFF.

**FSM states**
- `WAIT_CMD`: a received byte with bits[7:6] = 01 starts a command. Any other byte is ignored.
- `CMD_RX`: collects 5 more bytes (argument[31:0], CRC). The CRC is ignored.
- `RESP`: one 0xFF byte (NCR = 1), then the response bytes from a 5-byte buffer. Next state depends on the command.
- `RD_TOKEN`: one 0xFF gap byte, then 0xFE.
- `RD_DATA`: 512 bytes from memory.
- `RD_CRC`: 0xFF, 0xFF, then `WAIT_CMD`.
- `WR_TOKEN`: waits for a received 0xFE. Other bytes are ignored.
- `WR_DATA`: receives 512 bytes.
- `WR_CRC`: receives 2 bytes and ignores them.
- `WR_DRESP`: sends 0x05, then `BUSY_BYTES` × 0x00, then 0xFF, then `WAIT_CMD`.

**Command responses** (`i` = `idle`)
- CMD0: `idle` ← 1. R1 = 0x01.
- CMD8: R7 = 0x0i, 0x00, 0x00, arg[15:8], arg[7:0]. Echoes voltage and check pattern.
- CMD55: R1 = 0x0i. Sets the `app` flag, which is cleared by any following command.
- CMD41 with `app` set: `idle` ← 0. R1 = 0x00.
- CMD58: R1 0x0i, then OCR 0xC0FF8000 (SDHC, powered up).
- CMD16: R1 0x0i. The argument is ignored.
- CMD17 / CMD24 while `idle` = 1: R1 0x05, back to `WAIT_CMD`.
- CMD17 / CMD24 with LBA ≥ capacity: R1 0x40, back to `WAIT_CMD`.
- CMD17 / CMD24 otherwise: R1 0x00, then the read or write path.
- Any other command: R1 = 0x04 | i.

**Addressing and memory access**
- Block addressing (SDHC): LBA = arg. `mem_addr` = {LBA[ADDR_WIDTH-10:0], idx[8:0]}.
- Read: `mem_rd` pulses once per data byte at the start of the preceding slot. `mem_rdata` is captured on the following clk.
- Write: `mem_we` pulses once with `mem_addr`/`mem_wdata` 2 clks after data byte i completes. idx wraps 511 → 0 only via the state exit.

## Timing
- Reset values: `sdMISO` 1, `mem_rd` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `idle` 1. FSM in `WAIT_CMD`, `app` 0.
- SCLK edge to MISO change: 3 clks (2 synchroniser + 1 register).
- Response R1 appears in the second byte slot after the CRC byte.
- For CMD17, 0xFE appears in the second slot after R1.
- Each strobe is exactly one clk wide. At most one strobe per byte slot.
- Simultaneous CS rise and byte completion: CS wins. The byte is discarded and nothing is written.

## Test plan
- Reset, then CMD0 (40 00 00 00 00 95) → MISO FF, then 01. `idle` = 1.
- CMD8 arg 0x000001AA → FF, 01 00 00 01 AA.
- CMD55 then CMD41 → 01, then 00. `idle` falls. CMD58 → 00 C0 FF 80 00.
- Preload block 3 with bytes i^0x5A. CMD17 arg 3 → 00, FF, FE, 512 bytes matching, FF FF. `mem_addr` spans 0x0600–0x07FF with exactly 512 `mem_rd` pulses.
- CMD24 arg 5, token FE, 512 bytes of idx[7:0], 2 CRC bytes → 0x05, four 00, FF. Memory 0x0A00–0x0BFF holds the pattern.
- Start CMD24 and raise CS after 100 data bytes → exactly 100 `mem_we` pulses, MISO = 1. A fresh CMD0 is answered with 01.
